// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX register and the MEM stage.
//
// Computes the ALU result, zero flag and branch target for ordinary
// instructions and registers them into the EX/MEM outputs with one cycle of
// latency. Multiplies run on an iterative shift-add engine that retires
// MUL_STEP multiplier bits per cycle. While a multiply is in flight, stall
// freezes the upstream stages, and the EX/MEM control bits carry a bubble.
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   inR1             operand A
//   inR2             operand B / store data
//   inAddress        sign-extended immediate
//   inPc             PC+4 of the instruction
//   inAluCtrl        00 add, 01 sub, 10 and, 11 or
//   inControlBits    [0]aluSrc [1]regWrite [2]memRead [3]memWrite
//                    [4]memToReg [5]branch [6]mul [7]spare
//   inWriteRegister  destination register
//   flush            kill the instruction currently in EX
//   stall            hold ID/EX and earlier stages this cycle
//   outAluResult     ALU or multiply result
//   outR2            store data
//   outBranchTarget  inPc + (inAddress << 2)
//   outZero          outAluResult == 0
//   outControlBits   control passthrough, 0 = bubble
//   outWriteRegister destination passthrough
module ex_stage #(
  parameter int MUL_STEP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inR1,
  input  logic [31:0] inR2,
  input  logic [31:0] inAddress,
  input  logic [31:0] inPc,
  input  logic [1:0]  inAluCtrl,
  input  logic [7:0]  inControlBits,
  input  logic [4:0]  inWriteRegister,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] outAluResult,
  output logic [31:0] outR2,
  output logic [31:0] outBranchTarget,
  output logic        outZero,
  output logic [7:0]  outControlBits,
  output logic [4:0]  outWriteRegister
);

  localparam int N  = 32 / MUL_STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t        state;
  logic [31:0]   mulA;
  logic [31:0]   mulB;
  logic [31:0]   acc;
  logic [CW-1:0] count;
  logic [7:0]    capCtrl;
  logic [4:0]    capWr;
  logic [31:0]   capR2;
  logic [31:0]   capTarget;

  logic [31:0]   operandB;
  logic [31:0]   aluResult;
  logic [31:0]   branchTarget;
  logic [31:0]   partial;

  // Operand selection, ALU and branch target for the instruction on the inputs
  always_comb begin
    operandB     = inControlBits[0] ? inAddress : inR2;
    branchTarget = inPc + (inAddress << 2);
    case (inAluCtrl)
      2'b00:   aluResult = inR1 + operandB;
      2'b01:   aluResult = inR1 - operandB;
      2'b10:   aluResult = inR1 & operandB;
      default: aluResult = inR1 | operandB;
    endcase
  end

  // mulA is pre-shifted by MUL_STEP every iteration, so this partial product
  // already carries the count*MUL_STEP weight; only the low 32 bits matter
  always_comb begin
    partial = mulA * 32'(mulB[MUL_STEP-1:0]);
  end

  // Stall covers the multiply start cycle and every iteration; a flush always
  // lets the pipeline move so the killed instruction drains out
  always_comb begin
    stall = 1'b0;
    if (!flush) begin
      case (state)
        IDLE:    stall = inControlBits[6];
        MUL:     stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Main FSM and EX/MEM register; data outputs hold their values on a bubble
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      mulA             <= '0;
      mulB             <= '0;
      acc              <= '0;
      count            <= '0;
      capCtrl          <= '0;
      capWr            <= '0;
      capR2            <= '0;
      capTarget        <= '0;
      outAluResult     <= '0;
      outR2            <= '0;
      outBranchTarget  <= '0;
      outZero          <= 1'b0;
      outControlBits   <= '0;
      outWriteRegister <= '0;
    end else if (flush) begin
      outControlBits <= '0;
      state          <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (inControlBits[6]) begin
            mulA           <= inR1;
            mulB           <= operandB;
            acc            <= '0;
            count          <= '0;
            capCtrl        <= inControlBits;
            capWr          <= inWriteRegister;
            capR2          <= inR2;
            capTarget      <= branchTarget;
            outControlBits <= '0;
            state          <= MUL;
          end else begin
            outAluResult     <= aluResult;
            outZero          <= (aluResult == 32'd0);
            outR2            <= inR2;
            outBranchTarget  <= branchTarget;
            outControlBits   <= inControlBits;
            outWriteRegister <= inWriteRegister;
          end
        end
        MUL: begin
          acc   <= acc + partial;
          mulA  <= mulA << MUL_STEP;
          mulB  <= mulB >> MUL_STEP;
          count <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          outAluResult     <= acc;
          outZero          <= (acc == 32'd0);
          outR2            <= capR2;
          outBranchTarget  <= capTarget;
          outControlBits   <= capCtrl;
          outWriteRegister <= capWr;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
